vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator: it produces sync, data-enable and pixel-coordinate outputs for any mode up to 4095×4095 total. Mode geometry and sync polarity are runtime-programmable through a valid/ready config port. New geometry is held in a shadow register and applied only at a frame boundary. The block runs on the system clock with a pixel clock-enable, and sits between the clock divider and the pixel-source/RGB mux in the display top level.

## Interface
Parameters:
- CW, 12, counter/coordinate width; all geometry fields are CW bits.
- RST_MODE, vga_pkg::VGA_640X480, vga_timing_t geometry loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- pix_ce  in  1  pixel clock-enable; the timing advances one pixel per clk with pix_ce=1.
- cfg_valid  in  1  new geometry offered.
- cfg_ready  out  1  low while a shadow config awaits application.
- cfg  in  vga_timing_t  {h_act,h_fp,h_sync,h_bp,h_pol,v_act,v_fp,v_sync,v_bp,v_pol}; pol=1 means an active-high pulse.
- cfg_err  out  1  one-clk pulse when an offered config is rejected.
- h_sync  out  1  horizontal sync, polarity per the active config.
- v_sync  out  1  vertical sync, polarity per the active config.
- de  out  1  data enable, active-high in the visible area.
- x  out  CW  horizontal coordinate of the current pixel.
- y  out  CW  vertical coordinate of the current pixel.
- line_start  out  1  one-clk pulse at x=0 of every line.
- frame_start  out  1  one-clk pulse at x=0,y=0.

## Operation
- Horizontal total Ht = h_act+h_fp+h_sync+h_bp. Vertical total Vt is formed the same way from the v_ fields.
- Counters h_cnt and v_cnt advance only on pix_ce.
  - h_cnt wraps Ht−1→0.
  - v_cnt increments on h wrap and wraps Vt−1→0 when h_cnt also wraps.
- Decode, registered on pix_ce from the current h_cnt/v_cnt:
  - de = (h_cnt<h_act)&&(v_cnt<v_act).
  - x=h_cnt; y=v_cnt.
  - h_sync = pol when h_cnt∈[h_act+h_fp, h_act+h_fp+h_sync−1], else ~pol.
  - v_sync is decoded the same way from v_cnt, using line (not pixel) granularity.
- Strobes:
  - line_start = (h_cnt==0) and frame_start = (h_cnt==0&&v_cnt==0), each asserted for exactly one clk after the pix_ce that registered them.
  - Both are 0 on all other clks.
- Config handshake:
  - A transfer occurs on cfg_valid&&cfg_ready.
  - Validation happens on transfer. The config is rejected if any of h_act, v_act, h_sync or v_sync is 0, or if Ht>2^CW or Vt>2^CW. Totals are computed at CW+2 bits.
  - Rejected config: cfg_err pulses for 1 clk, nothing is stored, and cfg_ready stays high.
  - Accepted config: it is stored in the shadow register, pending=1, and cfg_ready=0.
- Apply: on the pix_ce where h_cnt==Ht−1 and v_cnt==Vt−1 (frame wrap) with pending=1:
  - active←shadow, pending←0.
  - Counters go to 0,0 as normal.
  - Sync/de decode from the next pix_ce onward uses the new geometry.
- Simultaneous events:
  - A config accepted in the same clk as a frame wrap is not applied at that wrap; it applies at the next wrap.
  - cfg_valid while cfg_ready=0 is ignored; it is neither an error nor an overwrite.
- pix_ce=0 holds every counter and every registered output except the strobes, which drop to 0.

## Timing
- Reset values:
  - h_cnt=v_cnt=0; x=0, y=0.
  - de=0, line_start=0, frame_start=0, cfg_err=0.
  - h_sync=~RST_MODE.h_pol and v_sync=~RST_MODE.v_pol.
  - cfg_ready=1; pending=0; active=RST_MODE.
- Latency: outputs lag the counters by one pix_ce. The x, y, de, syncs and strobes presented together always describe the same pixel.
- The first outputs after reset release appear on the clk following the first pix_ce: x=0,y=0,de=1,frame_start=1.
- cfg_ready drops in the clk after acceptance. It returns high in the clk after the applying frame wrap.
- Reset mid-frame discards the pending config and restarts at 0,0 in RST_MODE.

## Structure
- Package vga_pkg holds:
  - the packed struct vga_timing_t;
  - the constants VGA_640X480 ({640,16,96,48,0,480,10,2,33,0}) and VGA_800X600 ({800,40,128,88,1,600,1,4,23,1});
  - the function vga_timing_valid(cfg, CW).
- Sub-module vga_axis_counter is instantiated twice (horizontal and vertical).
  - Inputs: count_en, act, fp, sync, bp, pol.
  - Outputs: cnt, active, sync_out, last.
  - The vertical instance is enabled by pix_ce && h.last.

## Test plan
- Reset, pix_ce=1 every clk, RST_MODE 640x480 → Ht=800 and Vt=525 measured between frame_start pulses (420000 clks). h_sync is low for exactly 96 pixels starting at x=656, and de is high for 640×480 pixels per frame.
- pix_ce asserted every 4th clk → identical output sequence at ¼ rate. Strobes are 1 clk wide, and all outputs hold between enables.
- Offer VGA_800X600 mid-frame → cfg_ready=0 until the frame wrap. The next frame has Ht=1056 and Vt=628, and h_sync is high for 128 pixels from x=840.
- Offer a config with h_act=0, then one with h_act=4000 and h_fp=h_sync=h_bp=100 (CW=12) → cfg_err pulses twice, cfg_ready stays 1, and the geometry is unchanged.
- Offer a valid config in the same clk as the frame wrap → it is applied only at the following wrap (one full old-mode frame in between).
- Assert reset at x=300,y=200 with a config pending → outputs return to their reset values immediately. After release, the timing is 640x480 and cfg_ready=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator.
//   vga_timing_t     : packed mode geometry {h_act,h_fp,h_sync,h_bp,h_pol,
//                      v_act,v_fp,v_sync,v_bp,v_pol}; pol=1 is an active-high pulse
//   VGA_640X480/800X600 : standard modes
//   vga_timing_valid : accept/reject rule for a config offered at runtime
package vga_pkg;

  localparam int unsigned VGA_FW = 12;

  typedef struct packed {
    logic [VGA_FW-1:0] h_act;
    logic [VGA_FW-1:0] h_fp;
    logic [VGA_FW-1:0] h_sync;
    logic [VGA_FW-1:0] h_bp;
    logic              h_pol;
    logic [VGA_FW-1:0] v_act;
    logic [VGA_FW-1:0] v_fp;
    logic [VGA_FW-1:0] v_sync;
    logic [VGA_FW-1:0] v_bp;
    logic              v_pol;
  } vga_timing_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } vga_cfg_state_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_act: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48, h_pol: 1'b0,
    v_act: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33, v_pol: 1'b0
  };

  localparam vga_timing_t VGA_800X600 = '{
    h_act: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88, h_pol: 1'b1,
    v_act: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23, v_pol: 1'b1
  };

  // Two extra bits so the sum of four full-scale fields cannot wrap.
  function automatic logic [VGA_FW+1:0] axis_total(input logic [VGA_FW-1:0] a,
                                                   input logic [VGA_FW-1:0] f,
                                                   input logic [VGA_FW-1:0] s,
                                                   input logic [VGA_FW-1:0] b);
    return {2'b00, a} + {2'b00, f} + {2'b00, s} + {2'b00, b};
  endfunction

  function automatic logic vga_timing_valid(input vga_timing_t c, input int unsigned cw);
    logic [VGA_FW+1:0] ht;
    logic [VGA_FW+1:0] vt;
    logic [VGA_FW+1:0] lim;
    ht  = axis_total(c.h_act, c.h_fp, c.h_sync, c.h_bp);
    vt  = axis_total(c.v_act, c.v_fp, c.v_sync, c.v_bp);
    lim = (VGA_FW+2)'(1) << cw;
    return (c.h_act != '0) && (c.v_act != '0) && (c.h_sync != '0) &&
           (c.v_sync != '0) && (ht <= lim) && (vt <= lim);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis (horizontal or vertical).
//   count_en           : advance by one position
//   act/fp/sync/bp/pol : geometry of this axis
//   cnt                : current position
//   active             : cnt inside the visible region
//   sync_out           : sync level decoded from cnt (combinational)
//   last               : cnt is the final position; next advance wraps to 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          count_en,
  input  logic [CW-1:0] act,
  input  logic [CW-1:0] fp,
  input  logic [CW-1:0] sync,
  input  logic [CW-1:0] bp,
  input  logic          pol,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync_out,
  output logic          last
);

  logic [CW+1:0] cnt_w;
  logic [CW+1:0] sync_start;
  logic [CW+1:0] sync_end;
  logic [CW+1:0] total;

  always_comb begin
    cnt_w      = {2'b00, cnt};
    sync_start = {2'b00, act} + {2'b00, fp};
    sync_end   = sync_start + {2'b00, sync};
    total      = sync_end + {2'b00, bp};
    active     = (cnt < act);
    sync_out   = ((cnt_w >= sync_start) && (cnt_w < sync_end)) ? pol : ~pol;
    last       = (cnt_w == (total - {{(CW+1){1'b0}}, 1'b1}));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with runtime-programmable geometry.
//   clk, reset       : system clock, async active-high reset
//   pix_ce           : pixel clock-enable
//   cfg_valid/ready  : config handshake; cfg is the offered geometry
//   cfg_err          : one-clk pulse when an offered config is rejected
//   h_sync, v_sync   : syncs, polarity from the active config
//   de, x, y         : data enable and pixel coordinates
//   line_start       : one-clk pulse for x=0
//   frame_start      : one-clk pulse for x=0,y=0
// Outputs are registered on pix_ce and lag the counters by one pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW       = 12,
  parameter vga_timing_t RST_MODE = VGA_640X480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  vga_timing_t   cfg,
  output logic          cfg_err,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  vga_cfg_state_t state, state_nxt;
  vga_timing_t    active_cfg, shadow;
  logic           accept, reject, apply;

  logic [CW-1:0]  h_cnt, v_cnt;
  logic           h_active, v_active, h_sync_d, v_sync_d, h_last, v_last;
  logic           frame_wrap;

  assign frame_wrap = pix_ce && h_last && v_last;
  assign cfg_ready  = (state == CFG_IDLE);

  vga_axis_counter #(.CW(CW)) u_h (
    .clk(clk), .reset(reset), .count_en(pix_ce),
    .act(CW'(active_cfg.h_act)), .fp(CW'(active_cfg.h_fp)),
    .sync(CW'(active_cfg.h_sync)), .bp(CW'(active_cfg.h_bp)), .pol(active_cfg.h_pol),
    .cnt(h_cnt), .active(h_active), .sync_out(h_sync_d), .last(h_last)
  );

  vga_axis_counter #(.CW(CW)) u_v (
    .clk(clk), .reset(reset), .count_en(pix_ce && h_last),
    .act(CW'(active_cfg.v_act)), .fp(CW'(active_cfg.v_fp)),
    .sync(CW'(active_cfg.v_sync)), .bp(CW'(active_cfg.v_bp)), .pol(active_cfg.v_pol),
    .cnt(v_cnt), .active(v_active), .sync_out(v_sync_d), .last(v_last)
  );

  // Apply reads the registered pending state, so a config accepted on a
  // frame-wrap clk waits for the following wrap.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    apply     = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (cfg_valid) begin
          if (vga_timing_valid(cfg, CW)) begin
            accept    = 1'b1;
            state_nxt = CFG_PENDING;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CFG_PENDING: begin
        if (frame_wrap) begin
          apply     = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CFG_IDLE;
      shadow     <= RST_MODE;
      active_cfg <= RST_MODE;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= reject;
      if (accept) shadow     <= cfg;
      if (apply)  active_cfg <= shadow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      h_sync      <= ~RST_MODE.h_pol;
      v_sync      <= ~RST_MODE.v_pol;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && (h_cnt == '0);
      frame_start <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
      if (pix_ce) begin
        x      <= h_cnt;
        y      <= v_cnt;
        de     <= h_active && v_active;
        h_sync <= h_sync_d;
        v_sync <= v_sync_d;
      end
    end
  end

endmodule
